// File: rtl/sram_pixel_writer.sv
// Buffers receiver pixels in a small FIFO and writes them to the 16-bit async
// SRAM as byte-lane writes; serves single-byte reads once the receiver is done.
module sram_pixel_writer #(
    parameter int FIFO_DEPTH = 4,
    parameter int WE_CYCLES  = 2
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [7:0]  pixel_value,
    input  logic [19:0] addr_store,
    input  logic        store_finish,
    input  logic        rd_req,
    input  logic [19:0] rd_addr,
    output logic        rd_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        overflow,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);
    // state     | meaning
    // IDLE      | SRAM released; pop a queued pixel, else accept a read
    // WR_SETUP  | address, data and lane driven, we_n high
    // WR_PULSE  | we_n low for WE_CYCLES cycles
    // WR_HOLD   | we_n high, address and data still held
    // RD_ADDR   | ce_n/oe_n low on the selected lane, bus released
    // RD_SAMPLE | capture the selected byte of the pad data
    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ADDR, RD_SAMPLE
    } state_t;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(WE_CYCLES + 1);

    state_t        state;
    logic [19:0]   prev_addr;
    logic [27:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic [CW-1:0] we_cnt;
    logic [27:0]   head;
    logic          rd_lane;
    logic          rd_pend;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          rd_accept;
    logic          fsm_busy_next;

    assign push       = (addr_store != prev_addr);
    assign full       = (count == (PW+1)'(FIFO_DEPTH));
    assign pop        = (state == IDLE) && (count != '0);
    assign push_ok    = push && (!full || pop);
    assign count_next = count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
    assign head       = fifo_mem[rd_ptr];
    assign rd_ready   = store_finish && (state == IDLE) && (count == '0);
    assign rd_accept  = rd_req && rd_ready;

    always_comb begin
        fsm_busy_next = 1'b1;
        case (state)
            IDLE:               fsm_busy_next = pop || rd_accept;
            WR_HOLD, RD_SAMPLE: fsm_busy_next = 1'b0;
            default:            fsm_busy_next = 1'b1;
        endcase
    end

    always_ff @(posedge avm_clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= {addr_store, pixel_value};
    end

    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            prev_addr <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            prev_addr <= addr_store;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !push_ok) overflow <= 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            state      <= IDLE;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_pend    <= 1'b0;
            rd_lane    <= 1'b0;
            we_cnt     <= '0;
            busy       <= 1'b0;
        end else begin
            // rd_valid trails the capture by one cycle so it lands once rd_data has settled
            rd_valid <= rd_pend;
            rd_pend  <= 1'b0;
            busy     <= (count_next != '0) || fsm_busy_next;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state      <= WR_SETUP;
                        sram_addr  <= {1'b0, head[27:9]};
                        sram_dq_o  <= {head[7:0], head[7:0]};
                        sram_dq_oe <= 1'b1;
                        sram_ce_n  <= 1'b0;
                        sram_we_n  <= 1'b1;
                        sram_ub_n  <= ~head[8];
                        sram_lb_n  <= head[8];
                    end else if (rd_accept) begin
                        state     <= RD_ADDR;
                        sram_addr <= {1'b0, rd_addr[19:1]};
                        rd_lane   <= rd_addr[0];
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        sram_ub_n <= ~rd_addr[0];
                        sram_lb_n <= rd_addr[0];
                    end
                end
                WR_SETUP: begin
                    state     <= WR_PULSE;
                    sram_we_n <= 1'b0;
                    we_cnt    <= CW'(WE_CYCLES - 1);
                end
                WR_PULSE: begin
                    if (we_cnt == '0) begin
                        state     <= WR_HOLD;
                        sram_we_n <= 1'b1;
                    end else begin
                        we_cnt <= we_cnt - 1'b1;
                    end
                end
                WR_HOLD: begin
                    state      <= IDLE;
                    sram_dq_oe <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_ub_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                end
                RD_ADDR: state <= RD_SAMPLE;
                RD_SAMPLE: begin
                    state     <= IDLE;
                    rd_data   <= rd_lane ? sram_dq_i[15:8] : sram_dq_i[7:0];
                    rd_pend   <= 1'b1;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    sram_dq_oe <= 1'b0;
                    sram_ce_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_we_n  <= 1'b1;
                    sram_ub_n  <= 1'b1;
                    sram_lb_n  <= 1'b1;
                end
            endcase
        end
    end
endmodule
